tile_vga_ctrl: RTL and testbench

Parametrised VGA display controller for the block game, successor to the fixed 4×8 column renderer. Generates 800×600 timing from the 50 MHz pixel clock and renders an N_COLS × N_ROWS grid of colour tiles from flattened column data. Column data is captured once per frame in a shadow register, so tile updates never tear mid-frame. A per-pixel overlay (score text and number generators) is merged according to game state. The block sits between the game logic and the VGA pins; its pixel coordinates feed the overlay generators.

---
 rtl/tile_vga_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_tile_vga_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_vga_ctrl.sv
// Tile-grid VGA controller: 800x600 timing, per-frame shadowed tile colours, overlay merge.
// Optional build macro GRID_LINES_EN draws white tile borders in PLAY.
module tile_vga_ctrl #(
   parameter int N_COLS   = 4,
   parameter int N_ROWS   = 8,
   parameter int COLOR_W  = 3,
   parameter int TILE_W   = 200,
   parameter int TILE_H   = 75,
   parameter int H_TOTAL  = 1040,
   parameter int H_SYNC   = 120,
   parameter int H_START  = 187,
   parameter int H_ACTIVE = 800,
   parameter int V_TOTAL  = 666,
   parameter int V_SYNC   = 6,
   parameter int V_START  = 31,
   parameter int V_ACTIVE = 600
) (
   input  logic                              CLK_50M,
   input  logic                              RST_N,
   input  logic [1:0]                        game_state,
   input  logic [N_COLS*N_ROWS*COLOR_W-1:0]  columns,
   input  logic                              overlay_en,
   input  logic [COLOR_W-1:0]                overlay_rgb,
   output logic [9:0]                        x_pos,
   output logic [9:0]                        y_pos,
   output logic                              active,
   output logic                              frame_start,
   output logic                              hsync,
   output logic                              vsync,
   output logic [COLOR_W-1:0]                vga_rgb
);

   typedef enum logic [1:0] {
      GS_START = 2'b00,
      GS_PLAY  = 2'b01,
      GS_OVER  = 2'b10,
      GS_RSVD  = 2'b11
   } game_state_e;

   localparam int DATA_W = N_COLS * N_ROWS * COLOR_W;
   localparam int X_W    = $clog2(H_TOTAL);
   localparam int Y_W    = $clog2(V_TOTAL);
   localparam int TX_W   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int TY_W   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   // Tile indices never exceed the active extent, which fits the 10-bit position range.
   localparam int IDX_W  = 10;

   localparam logic [X_W-1:0]  X_LAST    = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0]  X_SYNC    = X_W'(H_SYNC);
   localparam logic [X_W-1:0]  X_PRE     = X_W'(H_START - 1);
   localparam logic [X_W-1:0]  X_ACT_BEG = X_W'(H_START);
   localparam logic [X_W-1:0]  X_ACT_END = X_W'(H_START + H_ACTIVE);
   localparam logic [Y_W-1:0]  Y_LAST    = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0]  Y_SYNC    = Y_W'(V_SYNC);
   localparam logic [Y_W-1:0]  Y_PRE     = Y_W'(V_START - 1);
   localparam logic [Y_W-1:0]  Y_ACT_BEG = Y_W'(V_START);
   localparam logic [Y_W-1:0]  Y_ACT_END = Y_W'(V_START + V_ACTIVE);
   localparam logic [TX_W-1:0] TX_LAST   = TX_W'(TILE_W - 1);
   localparam logic [TY_W-1:0] TY_LAST   = TY_W'(TILE_H - 1);

   logic [X_W-1:0]     r_x_cnt;
   logic [Y_W-1:0]     r_y_cnt;
   logic [TX_W-1:0]    r_tile_x;
   logic [TY_W-1:0]    r_tile_y;
   logic [IDX_W-1:0]   r_col_idx;
   logic [IDX_W-1:0]   r_row_idx;
   logic [DATA_W-1:0]  r_shadow;

   logic               r1_active;
   logic [IDX_W-1:0]   r1_col_idx;
   logic [IDX_W-1:0]   r1_row_idx;
   logic               r1_ovl_en;
   logic [COLOR_W-1:0] r1_ovl_rgb;
   logic               r1_hsync_raw;
   logic               r1_vsync_raw;
   game_state_e        r1_state;
`ifdef GRID_LINES_EN
   logic               r1_edge;
`endif

   logic               w_x_wrap;
   logic               w_y_last;
   logic               w_h_act;
   logic               w_v_act;
   logic               w_active;
   logic               w_in_grid;
   logic [COLOR_W-1:0] w_tile_rgb;
   logic [COLOR_W-1:0] w_pix_rgb;

   assign w_x_wrap = (r_x_cnt == X_LAST);
   assign w_y_last = (r_y_cnt == Y_LAST);
   assign w_h_act  = (r_x_cnt >= X_ACT_BEG) && (r_x_cnt < X_ACT_END);
   assign w_v_act  = (r_y_cnt >= Y_ACT_BEG) && (r_y_cnt < Y_ACT_END);
   assign w_active = w_h_act && w_v_act;

   assign x_pos       = 10'(r_x_cnt - X_ACT_BEG);
   assign y_pos       = 10'(r_y_cnt - Y_ACT_BEG);
   assign active      = w_active;
   // Held low during reset so the first pulse marks the first running cycle.
   assign frame_start = RST_N && (r_x_cnt == '0) && (r_y_cnt == '0);

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         r_x_cnt <= '0;
         r_y_cnt <= '0;
      end else begin
         r_x_cnt <= w_x_wrap ? '0 : r_x_cnt + X_W'(1);
         if (w_x_wrap)
            r_y_cnt <= w_y_last ? '0 : r_y_cnt + Y_W'(1);
      end
   end

   // Column tracking: restart just before the first active pixel of every line.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         r_tile_x  <= '0;
         r_col_idx <= '0;
      end else if (r_x_cnt == X_PRE) begin
         r_tile_x  <= '0;
         r_col_idx <= '0;
      end else if (w_h_act) begin
         if (r_tile_x == TX_LAST) begin
            r_tile_x  <= '0;
            r_col_idx <= r_col_idx + IDX_W'(1);
         end else begin
            r_tile_x  <= r_tile_x + TX_W'(1);
         end
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         r_tile_y  <= '0;
         r_row_idx <= '0;
      end else if (w_x_wrap) begin
         if (r_y_cnt == Y_PRE) begin
            r_tile_y  <= '0;
            r_row_idx <= '0;
         end else if (w_v_act) begin
            if (r_tile_y == TY_LAST) begin
               r_tile_y  <= '0;
               r_row_idx <= r_row_idx + IDX_W'(1);
            end else begin
               r_tile_y  <= r_tile_y + TY_W'(1);
            end
         end
      end
   end

   // Capture on the last clock of the first blanking line so a frame never tears.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N)
         r_shadow <= '0;
      else if (w_x_wrap && (r_y_cnt == Y_ACT_END))
         r_shadow <= columns;
   end

   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         r1_active    <= 1'b0;
         r1_col_idx   <= '0;
         r1_row_idx   <= '0;
         r1_ovl_en    <= 1'b0;
         r1_ovl_rgb   <= '0;
         r1_hsync_raw <= 1'b1;
         r1_vsync_raw <= 1'b1;
         r1_state     <= GS_START;
`ifdef GRID_LINES_EN
         r1_edge      <= 1'b0;
`endif
      end else begin
         r1_active    <= w_active;
         r1_col_idx   <= r_col_idx;
         r1_row_idx   <= r_row_idx;
         r1_ovl_en    <= overlay_en;
         r1_ovl_rgb   <= overlay_rgb;
         r1_hsync_raw <= !(r_x_cnt < X_SYNC);
         r1_vsync_raw <= !(r_y_cnt < Y_SYNC);
         r1_state     <= game_state_e'(game_state);
`ifdef GRID_LINES_EN
         r1_edge      <= (r_tile_x == '0) || (r_tile_x == TX_LAST) ||
                         (r_tile_y == '0) || (r_tile_y == TY_LAST);
`endif
      end
   end

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_tile_rgb = '0;
      w_in_grid  = 1'b0;
      for (int c = 0; c < N_COLS; c++) begin
         for (int r = 0; r < N_ROWS; r++) begin
            if ((r1_col_idx == IDX_W'(c)) && (r1_row_idx == IDX_W'(r))) begin
               w_tile_rgb = r_shadow[c*N_ROWS*COLOR_W + (N_ROWS-1-r)*COLOR_W +: COLOR_W];
               w_in_grid  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_pix_rgb = '0;
      if (!r1_active || (r1_state == GS_RSVD)) begin
         w_pix_rgb = '0;
      end else if (r1_ovl_en) begin
         w_pix_rgb = r1_ovl_rgb;
      end else if ((r1_state == GS_PLAY) && w_in_grid) begin
`ifdef GRID_LINES_EN
         w_pix_rgb = r1_edge ? '1 : w_tile_rgb;
`else
         w_pix_rgb = w_tile_rgb;
`endif
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         vga_rgb <= '0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
      end else begin
         vga_rgb <= w_pix_rgb;
         hsync   <= r1_hsync_raw;
         vsync   <= r1_vsync_raw;
      end
   end

endmodule

// File: tb/tb_tile_vga_ctrl.sv
// Directed bench for tile_vga_ctrl on a scaled-down raster (48x34 clocks, 24x26 active,
// 5x3 tiles) so each frame is 1632 clocks; expectations follow GRID_LINES_EN when defined.
module tb_tile_vga_ctrl;

   localparam int H_TOT = 48, H_SYN = 6, H_STA = 10, H_ACT = 24;
   localparam int V_TOT = 34, V_SYN = 2, V_STA = 3,  V_ACT = 26;
   localparam int T_W = 5, T_H = 3, N_C = 4, N_R = 8, C_W = 3;
   localparam int FRAME = H_TOT * V_TOT;

   localparam logic [1:0] GS_START = 2'b00, GS_PLAY = 2'b01, GS_OVER = 2'b10, GS_RSVD = 2'b11;

   logic                   clk;
   logic                   rst_n;
   logic [1:0]             game_state;
   logic [N_C*N_R*C_W-1:0] columns;
   logic                   overlay_en;
   logic [C_W-1:0]         overlay_rgb;
   logic [9:0]             x_pos;
   logic [9:0]             y_pos;
   logic                   active;
   logic                   frame_start;
   logic                   hsync;
   logic                   vsync;
   logic [C_W-1:0]         vga_rgb;

   int n_cmp = 0;
   int n_err = 0;
   int pos   = 0;

   tile_vga_ctrl #(
      .N_COLS(N_C), .N_ROWS(N_R), .COLOR_W(C_W), .TILE_W(T_W), .TILE_H(T_H),
      .H_TOTAL(H_TOT), .H_SYNC(H_SYN), .H_START(H_STA), .H_ACTIVE(H_ACT),
      .V_TOTAL(V_TOT), .V_SYNC(V_SYN), .V_START(V_STA), .V_ACTIVE(V_ACT)
   ) dut (
      .CLK_50M     (clk),
      .RST_N       (rst_n),
      .game_state  (game_state),
      .columns     (columns),
      .overlay_en  (overlay_en),
      .overlay_rgb (overlay_rgb),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .active      (active),
      .frame_start (frame_start),
      .hsync       (hsync),
      .vsync       (vsync),
      .vga_rgb     (vga_rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Colour of a tile-border pixel: white when grid lines are built in.
   function automatic int edge_px(input int plain);
`ifdef GRID_LINES_EN
      return 7;
`else
      return plain;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      pos++;
   endtask

   task automatic goto(input int rx, input int ry);
      int tgt;
      int n;
      tgt = ry * H_TOT + rx;
      n   = 0;
      while (((pos % FRAME) != tgt) && (n < FRAME)) begin
         tick();
         n++;
      end
   endtask

   // Drive one active pixel (with optional overlay) and check its colour two clocks later.
   task automatic pix(input string tag, input int ax, input int ay, input logic [1:0] st,
                      input logic en, input logic [2:0] rgb, input int exp);
      game_state = st;
      goto(ax + H_STA, ay + V_STA);
      overlay_en  = en;
      overlay_rgb = rgb;
      tick();
      overlay_en  = 1'b0;
      tick();
      check(tag, 32'(vga_rgb), exp);
   endtask

   initial begin
      int nh, nv, nfs, nact, nrgb, fs2;
      rst_n       = 1'b0;
      game_state  = GS_START;
      overlay_en  = 1'b0;
      overlay_rgb = '0;
      columns     = {24'o22222222, 24'o76543210, 24'o11111111, 24'o01234567};
      repeat (3) @(negedge clk);

      check("rst_hsync", 32'(hsync), 1);
      check("rst_vsync", 32'(vsync), 1);
      check("rst_rgb", 32'(vga_rgb), 0);
      check("rst_active", 32'(active), 0);
      check("rst_frame_start", 32'(frame_start), 0);

      rst_n = 1'b1;
      #1;
      pos = 0;
      check("first_frame_start", 32'(frame_start), 1);

      nh = 0; nv = 0; nfs = 0; nact = 0; nrgb = 0; fs2 = -1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (!hsync) nh++;
         if (!vsync) nv++;
         if (active) nact++;
         if (vga_rgb != '0) nrgb++;
         if (frame_start) begin
            nfs++;
            if (nfs == 2) fs2 = pos;
         end
         tick();
      end
      check("hsync_low_2frames", 32'(nh), 2 * V_TOT * H_SYN);
      check("vsync_low_2frames", 32'(nv), 2 * V_SYN * H_TOT);
      check("frame_start_count", 32'(nfs), 2);
      check("frame_start_period", 32'(fs2), FRAME);
      check("active_count", 32'(nact), 2 * H_ACT * V_ACT);
      check("start_no_overlay_black", 32'(nrgb), 0);

      // Frame 2: PLAY with the shadow holding the initial columns.
      game_state = GS_PLAY;
      goto(0, 0);
      check("hsync_lag_x0", 32'(hsync), 1);
      check("vsync_lag_x0", 32'(vsync), 1);
      tick();
      check("hsync_lag_x1", 32'(hsync), 1);
      tick();
      check("hsync_lag_x2", 32'(hsync), 0);
      check("vsync_lag_x2", 32'(vsync), 0);
      goto(7, 0);
      check("hsync_lag_x7", 32'(hsync), 0);
      goto(8, 0);
      check("hsync_lag_x8", 32'(hsync), 1);
      goto(9, 3);
      check("active_before_start", 32'(active), 0);
      goto(10, 3);
      check("active_first", 32'(active), 1);
      check("x_pos_first", 32'(x_pos), 0);
      check("y_pos_first", 32'(y_pos), 0);

      pix("px_0_0", 0, 0, GS_PLAY, 1'b0, 3'd0, edge_px(0));
      pix("px_1_1", 1, 1, GS_PLAY, 1'b0, 3'd0, 0);
      pix("px_beyond_cols", 20, 1, GS_PLAY, 1'b0, 3'd0, 0);
      pix("px_last_col", 23, 1, GS_PLAY, 1'b0, 3'd0, 0);
      pix("px_1_4", 1, 4, GS_PLAY, 1'b0, 3'd0, 1);
      pix("px_col1_left", 5, 4, GS_PLAY, 1'b0, 3'd0, edge_px(1));
      check("x_pos_mid", 32'(x_pos), 7);
      check("y_pos_mid", 32'(y_pos), 4);
      pix("px_col1_mid", 8, 4, GS_PLAY, 1'b0, 3'd0, 1);
      pix("px_col2_row2", 11, 7, GS_PLAY, 1'b0, 3'd0, 5);
      pix("px_row7", 1, 22, GS_PLAY, 1'b0, 3'd0, 7);
      pix("px_row7_corner", 4, 23, GS_PLAY, 1'b0, 3'd0, 7);
      pix("px_beyond_rows", 19, 25, GS_PLAY, 1'b0, 3'd0, 0);
      goto(33, 28);
      check("active_last", 32'(active), 1);
      check("x_pos_last", 32'(x_pos), 23);
      check("y_pos_last", 32'(y_pos), 25);
      goto(34, 28);
      check("active_after_end", 32'(active), 0);
      goto(10, 29);
      check("active_vblank", 32'(active), 0);

      // Frame 3: columns change mid-frame; frame 4 shows the new data.
      pix("old_before_change", 1, 4, GS_PLAY, 1'b0, 3'd0, 1);
      goto(10, 16);
      columns = {24'o22222222, 24'o76543210, 24'o11111111, 24'o76543210};
      pix("old_after_change", 1, 22, GS_PLAY, 1'b0, 3'd0, 7);
      pix("new_next_frame_r1", 1, 4, GS_PLAY, 1'b0, 3'd0, 6);
      pix("new_next_frame_r7", 1, 22, GS_PLAY, 1'b0, 3'd0, 0);

      // Frame 5: overlay priority and exact two-clock latency.
      game_state = GS_OVER;
      goto(12, 5);
      overlay_en  = 1'b1;
      overlay_rgb = 3'b100;
      tick();
      overlay_en  = 1'b0;
      check("ovl_lat1", 32'(vga_rgb), 0);
      tick();
      check("ovl_lat2", 32'(vga_rgb), 4);
      tick();
      check("ovl_lat3", 32'(vga_rgb), 0);
      pix("over_tile_black", 11, 7, GS_OVER, 1'b0, 3'd0, 0);
      pix("rsvd_ovl_black", 5, 10, GS_RSVD, 1'b1, 3'd7, 0);
      pix("play_ovl_over_tile", 12, 14, GS_PLAY, 1'b1, 3'd2, 2);
      pix("play_ovl_beyond", 21, 14, GS_PLAY, 1'b1, 3'd6, 6);
      pix("ovl_inactive", 30, 15, GS_PLAY, 1'b1, 3'd5, 0);
      pix("start_ovl", 5, 17, GS_START, 1'b1, 3'd5, 5);
      pix("start_tile_black", 15, 21, GS_START, 1'b0, 3'd0, 0);

      // Frame 6: one-clock reset in the middle of the active area.
      game_state = GS_PLAY;
      goto(20, 15);
      check("pre_rst_rgb", 32'(vga_rgb), edge_px(1));
      rst_n = 1'b0;
      tick();
      check("mid_rst_rgb", 32'(vga_rgb), 0);
      check("mid_rst_active", 32'(active), 0);
      check("mid_rst_hsync", 32'(hsync), 1);
      check("mid_rst_frame_start", 32'(frame_start), 0);
      rst_n = 1'b1;
      #1;
      pos = 0;
      check("post_rst_frame_start", 32'(frame_start), 1);
      tick();
      check("post_rst_fs_pulse", 32'(frame_start), 0);
      pix("post_rst_shadow_clear", 1, 4, GS_PLAY, 1'b0, 3'd0, 0);
      pix("post_rst_reload", 1, 4, GS_PLAY, 1'b0, 3'd0, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
